// File: rtl/fp_arith_primitive_unit.sv
`default_nettype none
// ============================================================================
// Module      : fp_arith_primitive_unit
// Description : Registered 32-bit magnitude compare, 8-bit compare and 32-bit
//               add with carry for the single-precision add/sub datapath.
//               Optional macro FP_ARITH_OVF_EN adds a signed-overflow output.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_arith_primitive_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    input  logic [7:0]  ea,
    input  logic [7:0]  eb,
    output logic        out_valid,
    output logic [31:0] sum,
    output logic        cout,
    output logic        eq32,
    output logic        gt32,
    output logic        lt32,
    output logic        eq8,
    output logic        gt8,
    output logic        lt8
`ifdef FP_ARITH_OVF_EN
    ,
    output logic        ovf
`endif
);

    logic [32:0] w_add;
    logic        w_eq32;
    logic        w_gt32;
    logic        w_eq8;
    logic        w_gt8;

    logic        r_valid;
    logic [31:0] r_sum;
    logic        r_cout;
    logic        r_eq32;
    logic        r_gt32;
    logic        r_lt32;
    logic        r_eq8;
    logic        r_gt8;
    logic        r_lt8;

    always_comb begin
        w_add  = {1'b0, a} + {1'b0, b} + {32'd0, cin};
        w_eq32 = (a == b);
        w_gt32 = (a > b);
        w_eq8  = (ea == eb);
        w_gt8  = (ea > eb);
    end

    // Result registers hold across idle cycles; only the qualifier drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_sum   <= 32'd0;
            r_cout  <= 1'b0;
            r_eq32  <= 1'b0;
            r_gt32  <= 1'b0;
            r_lt32  <= 1'b0;
            r_eq8   <= 1'b0;
            r_gt8   <= 1'b0;
            r_lt8   <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_sum  <= w_add[31:0];
                r_cout <= w_add[32];
                r_eq32 <= w_eq32;
                r_gt32 <= w_gt32;
                r_lt32 <= ~w_eq32 & ~w_gt32;
                r_eq8  <= w_eq8;
                r_gt8  <= w_gt8;
                r_lt8  <= ~w_eq8 & ~w_gt8;
            end
        end
    end

`ifdef FP_ARITH_OVF_EN
    logic w_ovf;
    logic r_ovf;

    assign w_ovf = (a[31] == b[31]) && (w_add[31] != a[31]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (in_valid) begin
            r_ovf <= w_ovf;
        end
    end

    assign ovf = r_ovf;
`endif

    assign out_valid = r_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign eq32      = r_eq32;
    assign gt32      = r_gt32;
    assign lt32      = r_lt32;
    assign eq8       = r_eq8;
    assign gt8       = r_gt8;
    assign lt8       = r_lt8;

endmodule
`default_nettype wire

// File: tb/tb_fp_arith_primitive_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_arith_primitive_unit
// Description : Directed vector bench for fp_arith_primitive_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_arith_primitive_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [7:0]  ea;
    logic [7:0]  eb;
    logic        out_valid;
    logic [31:0] sum;
    logic        cout;
    logic        eq32, gt32, lt32, eq8, gt8, lt8;
`ifdef FP_ARITH_OVF_EN
    logic        ovf;
`endif

    always #5 clk = ~clk;

    fp_arith_primitive_unit dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .ea        (ea),
        .eb        (eb),
        .out_valid (out_valid),
        .sum       (sum),
        .cout      (cout),
        .eq32      (eq32),
        .gt32      (gt32),
        .lt32      (lt32),
        .eq8       (eq8),
        .gt8       (gt8),
        .lt8       (lt8)
`ifdef FP_ARITH_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [7:0]  ea;
        logic [7:0]  eb;
        logic [31:0] sum;
        logic        cout;
        logic [5:0]  flags;  // {eq32,gt32,lt32,eq8,gt8,lt8}
        logic        ovf;
    } vec_t;

    localparam int c_NVEC = 10;
    vec_t vecs[c_NVEC];

    int n_cmp = 0;
    int n_mis = 0;

    task automatic chk(input string nm, input logic [32:0] act, input logic [32:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [5:0] flags_now();
        return {eq32, gt32, lt32, eq8, gt8, lt8};
    endfunction

    task automatic check_all(input string nm, input logic v, input logic [31:0] s,
                             input logic c, input logic [5:0] f, input logic o);
        chk({nm, ".valid"}, {32'd0, out_valid}, {32'd0, v});
        chk({nm, ".sum"},   {1'b0, sum},        {1'b0, s});
        chk({nm, ".cout"},  {32'd0, cout},      {32'd0, c});
        chk({nm, ".flags"}, {27'd0, flags_now()}, {27'd0, f});
`ifdef FP_ARITH_OVF_EN
        chk({nm, ".ovf"},   {32'd0, ovf},       {32'd0, o});
`else
        if (o === 1'bx) $display("unexpected x in ovf expectation for %s", nm);
`endif
    endtask

    task automatic drive(input logic v, input logic [31:0] ia, input logic [31:0] ib,
                         input logic ic, input logic [7:0] iea, input logic [7:0] ieb);
        in_valid = v;
        a = ia;
        b = ib;
        cin = ic;
        ea = iea;
        eb = ieb;
    endtask

    initial begin
        //          a             b             cin  ea     eb     sum           cout flags      ovf
        vecs[0] = '{32'h0383C7AE, 32'h0164F5C3, 1'b0, 8'h00, 8'h00, 32'h04E8BD71, 1'b0, 6'b010100, 1'b0};
        vecs[1] = '{32'h3F7D70A4, 32'h3F7D70A4, 1'b0, 8'h7E, 8'h7E, 32'h7EFAE148, 1'b0, 6'b100100, 1'b0};
        vecs[2] = '{32'h3F7D70A4, 32'h3F7D70A4, 1'b0, 8'h7D, 8'h7E, 32'h7EFAE148, 1'b0, 6'b100001, 1'b0};
        vecs[3] = '{32'h0083C3AE, 32'h000727AE, 1'b0, 8'h80, 8'h7F, 32'h008AEB5C, 1'b0, 6'b010010, 1'b0};
        vecs[4] = '{32'h00FD70A4, 32'h00FD70A4, 1'b0, 8'h10, 8'h10, 32'h01FAE148, 1'b0, 6'b100100, 1'b0};
        vecs[5] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 8'h00, 8'hFF, 32'h00000000, 1'b1, 6'b010001, 1'b0};
        vecs[6] = '{32'h00000087, 32'h00000001, 1'b0, 8'h87, 8'h86, 32'h00000088, 1'b0, 6'b010010, 1'b0};
        vecs[7] = '{32'h00000001, 32'h00000002, 1'b1, 8'hFF, 8'h00, 32'h00000004, 1'b0, 6'b001010, 1'b0};
        vecs[8] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, 8'h01, 8'h02, 32'hFFFFFFFE, 1'b0, 6'b100001, 1'b1};
        vecs[9] = '{32'h80000000, 32'h80000000, 1'b0, 8'hFE, 8'hFE, 32'h00000000, 1'b1, 6'b100100, 1'b1};

        // Reset with in_valid high: reset must win.
        rst = 1'b1;
        drive(1'b1, 32'h12345678, 32'h00000001, 1'b1, 8'h05, 8'h01);
        @(posedge clk);
        @(negedge clk);
        check_all("reset", 1'b0, 32'd0, 1'b0, 6'b000000, 1'b0);
        rst = 1'b0;

        // Back-to-back valid operations, one result per cycle.
        for (int i = 0; i < c_NVEC; i++) begin
            drive(1'b1, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].ea, vecs[i].eb);
            @(posedge clk);
            @(negedge clk);
            check_all($sformatf("vec%0d", i), 1'b1, vecs[i].sum, vecs[i].cout,
                      vecs[i].flags, vecs[i].ovf);
        end

        // Idle with changed inputs: results hold, qualifier drops.
        drive(1'b0, 32'h00000001, 32'hFFFFFFFF, 1'b1, 8'h00, 8'h09);
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            check_all("hold", 1'b0, vecs[9].sum, vecs[9].cout, vecs[9].flags, vecs[9].ovf);
        end

        // Valid after idle, then reset mid-stream discards in-flight data.
        drive(1'b1, vecs[0].a, vecs[0].b, vecs[0].cin, vecs[0].ea, vecs[0].eb);
        @(posedge clk);
        @(negedge clk);
        check_all("resume", 1'b1, vecs[0].sum, vecs[0].cout, vecs[0].flags, vecs[0].ovf);
        drive(1'b1, vecs[8].a, vecs[8].b, vecs[8].cin, vecs[8].ea, vecs[8].eb);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_all("midrst", 1'b0, 32'd0, 1'b0, 6'b000000, 1'b0);
        rst = 1'b0;
        in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            check_all("post_rst", 1'b0, 32'd0, 1'b0, 6'b000000, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
